// File: rtl/blink_pkg.sv
// Shared widths, default periods and period helpers for the blink rate controller.
package blink_pkg;

  localparam int unsigned CNT_W          = 26;
  localparam int unsigned RATE_W         = 2;
  localparam int unsigned DEB_CYCLES_DEF = 5000;
  localparam int unsigned PERIOD0_DEF    = 5000;
  localparam int unsigned PERIOD1_DEF    = 10000;
  localparam int unsigned PERIOD2_DEF    = 25000;
  localparam int unsigned PERIOD3_DEF    = 50000;

  typedef logic [CNT_W-1:0]  period_t;
  typedef logic [RATE_W-1:0] rate_t;

  // A period must be at least 2 and its terminal count must fit the counter.
  function automatic bit period_ok(input int unsigned p);
    return (p >= 32'd2) && (p <= (32'd1 << CNT_W));
  endfunction

  // Terminal count (P-1) for the selected rate.
  function automatic period_t period_last(input rate_t sel,
                                          input int unsigned p0,
                                          input int unsigned p1,
                                          input int unsigned p2,
                                          input int unsigned p3);
    period_t last;
    case (sel)
      2'd0:    last = period_t'(p0 - 32'd1);
      2'd1:    last = period_t'(p1 - 32'd1);
      2'd2:    last = period_t'(p2 - 32'd1);
      default: last = period_t'(p3 - 32'd1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low push-button; strobes press one
// cycle after the debounced level falls.
module key_debounce
  import blink_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("key_debounce: DEB_CYCLES must be at least 1");
  end

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized key disagrees with the accepted level.
  always_comb begin
    s1_d         = key_n;
    s2_d         = s1_q;
    stable_d     = stable_q;
    cnt_d        = '0;
    stable_dly_d = stable_q;
    press_d      = stable_dly_q & ~stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q == DEB_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-selectable tick generator: each debounced press advances rate_sel
// and restarts the period counter at the new rate.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned PERIOD0    = PERIOD0_DEF,
  parameter int unsigned PERIOD1    = PERIOD1_DEF,
  parameter int unsigned PERIOD2    = PERIOD2_DEF,
  parameter int unsigned PERIOD3    = PERIOD3_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              key_n,
  output logic              tick,
  output logic [RATE_W-1:0] rate_sel,
  output logic              press
);

  if (!period_ok(PERIOD0) || !period_ok(PERIOD1) ||
      !period_ok(PERIOD2) || !period_ok(PERIOD3)) begin : g_bad_period
    $error("blink_rate_ctrl: every PERIODn must be in 2..2**CNT_W");
  end

  logic    press_w;
  logic    stable_unused;
  period_t last_c;
  period_t cnt_q, cnt_d;
  rate_t   rate_q, rate_d;
  logic    tick_q, tick_d;

  // The debounced level itself is not needed here, only its press strobe.
  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_n),
    .stable   (stable_unused),
    .press    (press_w)
  );

  // A press restarts the period at the new rate and swallows any pending tick.
  always_comb begin
    last_c = period_last(rate_q, PERIOD0, PERIOD1, PERIOD2, PERIOD3);
    cnt_d  = cnt_q + CNT_W'(1);
    rate_d = rate_q;
    tick_d = 1'b0;
    if (press_w) begin
      cnt_d  = '0;
      rate_d = rate_q + RATE_W'(1);
    end else if (cnt_q == last_c) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q  <= '0;
      rate_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
      tick_q <= tick_d;
    end
  end

  assign tick     = tick_q;
  assign rate_sel = rate_q;
  assign press    = press_w;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl with DEB_CYCLES=4 and periods 8/16/32/64.
module tb_blink_rate_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       key_n    = 1'b1;
  logic       tick;
  logic [1:0] rate_sel;
  logic       press;

  int checks   = 0;
  int failures = 0;

  blink_rate_ctrl #(
    .DEB_CYCLES (4),
    .PERIOD0    (8),
    .PERIOD1    (16),
    .PERIOD2    (32),
    .PERIOD3    (64)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_n),
    .tick     (tick),
    .rate_sel (rate_sel),
    .press    (press)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // Steps until tick is seen; lat is the number of edges taken, -1 on timeout.
  task automatic wait_tick(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (tick === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Pushes the key until press is seen, then releases it at that sample.
  task automatic do_press(output int lat);
    key_n = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (press === 1'b1) begin
        lat = i;
        break;
      end
    end
    key_n = 1'b1;
  endtask

  initial begin
    int np;
    int first;
    int lat;
    int tl;
    int exp_rate [4] = '{1, 2, 3, 0};
    int exp_per  [4] = '{16, 32, 64, 8};

    apply_reset(2);
    check("reset_tick", 32'(tick), 0);
    check("reset_press", 32'(press), 0);
    check("reset_rate", 32'(rate_sel), 0);

    // Idle: ticks every 8 edges after reset release.
    np = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("idle_tick_%0d", k), 32'(tick), (k % 8 == 0) ? 1 : 0);
      np += int'(press);
    end
    check("idle_press", np, 0);
    check("idle_rate", 32'(rate_sel), 0);

    // Three-cycle glitch is one sample short of acceptance.
    np = 0;
    key_n = 1'b0;
    repeat (3) begin step(); np += int'(press); end
    key_n = 1'b1;
    repeat (12) begin step(); np += int'(press); end
    check("glitch_press", np, 0);
    check("glitch_rate", 32'(rate_sel), 0);

    // Ten-cycle hold: one press, 7 edges after the drop; release gives none.
    np = 0;
    first = -1;
    key_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (press === 1'b1) begin
        np++;
        if (first < 0) first = i;
      end
    end
    key_n = 1'b1;
    repeat (15) begin step(); np += int'(press); end
    check("press_latency", first, 7);
    check("press_count", np, 1);
    check("press_rate", 32'(rate_sel), 1);

    // Four presses from reset: rate 1,2,3,0 and first tick P(new) after the press cycle.
    apply_reset(1);
    for (int i = 0; i < 4; i++) begin
      do_press(lat);
      check($sformatf("seq_press_lat_%0d", i), lat, 7);
      step();
      check($sformatf("seq_rate_%0d", i), 32'(rate_sel), exp_rate[i]);
      check($sformatf("seq_no_tick_%0d", i), 32'(tick), 0);
      wait_tick(200, tl);
      check($sformatf("seq_tick_lat_%0d", i), tl, exp_per[i]);
    end

    // Press lands while counter = 7 (P0-1): that tick is dropped, restart at P1.
    do_press(lat);
    check("align_press_lat", lat, 7);
    step();
    check("align_no_tick", 32'(tick), 0);
    check("align_rate", 32'(rate_sel), 1);
    wait_tick(200, tl);
    check("align_tick_lat", tl, 16);

    // Reset with debounce count 2 and period count 5 abandons both.
    step();
    key_n = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    key_n = 1'b1;
    step();
    reset = 1'b0;
    np = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("rst_mid_tick_%0d", k), 32'(tick), (k % 8 == 0) ? 1 : 0);
      np += int'(press);
    end
    check("rst_mid_press", np, 0);
    check("rst_mid_rate", 32'(rate_sel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
